// File: rtl/hmc_rsp_pkg.sv
// Shared types and constants for the HMC response collector.
// Holds the FSM state encoding and the saturating counter helper.
package hmc_rsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam int              NUM_TAGS_DEF = 32;
    localparam int              CNT_W        = 16;
    localparam logic [CNT_W-1:0] CNT_MAX     = 16'hFFFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hmc_rsp_collector_if.sv
// Batch control, HMC rx response and drain stream signals of the collector.
// Drain handshake: a beat transfers on a rising clk edge where out_valid && out_ready; while out_valid && !out_ready, out_data/out_idx/out_last hold stable.
interface hmc_rsp_collector_if
    import hmc_rsp_pkg::*;
#(
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_TAGS   = NUM_TAGS_DEF
);
    localparam int LEN_W = $clog2(NUM_TAGS) + 1;
    localparam int IDX_W = $clog2(NUM_TAGS);

    logic                  batch_start;
    logic [LEN_W-1:0]      batch_len;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [TAG_WIDTH-1:0]  rd_data_tag;
    logic                  rd_data_valid;
    logic [6:0]            errstat;
    logic                  dinv;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_last;
    logic                  batch_done;
    logic                  busy;
    logic                  tag_err;
    logic [CNT_W-1:0]      errstat_count;
    logic [CNT_W-1:0]      dinv_count;
    logic [6:0]            errstat_last;

    modport master (
        output batch_start, batch_len, rd_data, rd_data_tag, rd_data_valid,
               errstat, dinv, out_ready,
        input  out_valid, out_data, out_idx, out_last, batch_done, busy,
               tag_err, errstat_count, dinv_count, errstat_last
    );

    modport slave (
        input  batch_start, batch_len, rd_data, rd_data_tag, rd_data_valid,
               errstat, dinv, out_ready,
        output out_valid, out_data, out_idx, out_last, batch_done, busy,
               tag_err, errstat_count, dinv_count, errstat_last
    );

endinterface

// File: rtl/hmc_rsp_store.sv
// Batch payload buffer: one synchronous write port, one asynchronous read port.
module hmc_rsp_store #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_TAGS   = 32
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [$clog2(NUM_TAGS)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    input  logic [$clog2(NUM_TAGS)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]       rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_TAGS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hmc_rsp_collector.sv
// Gathers one batch of out-of-order HMC read responses by tag and drains it
// in tag order; also tracks error-status and data-invalid responses.
module hmc_rsp_collector
    import hmc_rsp_pkg::*;
#(
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_TAGS   = NUM_TAGS_DEF
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    hmc_rsp_collector_if.slave   bus,
    output state_e               state_o
);

    localparam int IDX_W = $clog2(NUM_TAGS);
    localparam int LEN_W = IDX_W + 1;
    localparam int CMP_W = (TAG_WIDTH > LEN_W) ? TAG_WIDTH : LEN_W;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      rcv_cnt_q, rcv_cnt_d;
    logic [NUM_TAGS-1:0]   vbits_q, vbits_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  tag_err_q, tag_err_d;
    logic [CNT_W-1:0]      errcnt_q, errcnt_d;
    logic [CNT_W-1:0]      dinvcnt_q, dinvcnt_d;
    logic [6:0]            errlast_q, errlast_d;

    logic [IDX_W-1:0]      slot;
    logic                  tag_in_range;
    logic                  wr_en;
    logic                  len_ok;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] slot_data;

    // Range check is done at full tag width so out-of-range tags never alias a slot.
    assign slot         = bus.rd_data_tag[IDX_W-1:0];
    assign tag_in_range = CMP_W'(bus.rd_data_tag) < CMP_W'(len_q);
    assign wr_en        = (state_q == ST_COLLECT) && bus.rd_data_valid
                          && tag_in_range && !vbits_q[slot];
    assign len_ok       = (bus.batch_len != '0) && (bus.batch_len <= LEN_W'(NUM_TAGS));
    assign last_beat    = LEN_W'(idx_q) == (len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rcv_cnt_d = rcv_cnt_q;
        vbits_d   = vbits_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        tag_err_d = tag_err_q;
        errcnt_d  = errcnt_q;
        dinvcnt_d = dinvcnt_q;
        errlast_d = errlast_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.batch_start) begin
                    if (len_ok) begin
                        state_d   = ST_COLLECT;
                        len_d     = bus.batch_len;
                        vbits_d   = '0;
                        rcv_cnt_d = '0;
                    end else begin
                        tag_err_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (wr_en) begin
                    vbits_d[slot] = 1'b1;
                    rcv_cnt_d     = rcv_cnt_q + LEN_W'(1);
                    if (rcv_cnt_d == len_q) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any response that is not stored is a protocol error, whatever the state.
        if (bus.rd_data_valid && !wr_en) begin
            tag_err_d = 1'b1;
        end
        if (bus.rd_data_valid && (bus.errstat != 7'd0)) begin
            errcnt_d  = sat_inc(errcnt_q);
            errlast_d = bus.errstat;
        end
        if (bus.rd_data_valid && bus.dinv) begin
            dinvcnt_d = sat_inc(dinvcnt_q);
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            rcv_cnt_q <= '0;
            vbits_q   <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            tag_err_q <= 1'b0;
            errcnt_q  <= '0;
            dinvcnt_q <= '0;
            errlast_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rcv_cnt_q <= rcv_cnt_d;
            vbits_q   <= vbits_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            tag_err_q <= tag_err_d;
            errcnt_q  <= errcnt_d;
            dinvcnt_q <= dinvcnt_d;
            errlast_q <= errlast_d;
        end
    end

    hmc_rsp_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAGS   (NUM_TAGS)
    ) u_store (
        .clk_i   (rx_clk),
        .we_i    (wr_en),
        .waddr_i (slot),
        .wdata_i (bus.rd_data),
        .raddr_i (idx_q),
        .rdata_o (slot_data)
    );

    assign bus.out_valid     = (state_q == ST_DRAIN);
    assign bus.out_data      = bus.out_valid ? slot_data : '0;
    assign bus.out_idx       = idx_q;
    assign bus.out_last      = bus.out_valid && last_beat;
    assign bus.batch_done    = done_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.tag_err       = tag_err_q;
    assign bus.errstat_count = errcnt_q;
    assign bus.dinv_count    = dinvcnt_q;
    assign bus.errstat_last  = errlast_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_hmc_rsp_collector.sv
// Scenario-driven bench for hmc_rsp_collector: expected beats are queued as
// responses are driven and compared as the collector drains them.
module tb_hmc_rsp_collector;
    import hmc_rsp_pkg::*;

    localparam int TW = 6;
    localparam int DW = 128;
    localparam int NT = 32;
    localparam int IW = $clog2(NT);

    logic   rx_clk;
    logic   rst;
    state_e state_o;

    hmc_rsp_collector_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .NUM_TAGS(NT)) bus ();

    hmc_rsp_collector #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .NUM_TAGS(NT)) dut (
        .rx_clk  (rx_clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] slot_exp[NT];
    logic [CNT_W-1:0] m_errcnt = '0;
    logic [CNT_W-1:0] m_dinvcnt = '0;
    logic [6:0]       m_errlast = '0;

    task automatic tick();
        @(negedge rx_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_errcnt  = '0;
        m_dinvcnt = '0;
        m_errlast = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_batch(input int len);
        bus.batch_start = 1'b1;
        bus.batch_len   = (IW + 1)'(len);
        tick();
        bus.batch_start = 1'b0;
    endtask

    task automatic send_rsp(input int tag, input logic [DW-1:0] data,
                            input logic [6:0] es, input logic dv);
        bus.rd_data_valid = 1'b1;
        bus.rd_data_tag   = TW'(tag);
        bus.rd_data       = data;
        bus.errstat       = es;
        bus.dinv          = dv;
        if (es != 7'd0) begin
            if (m_errcnt != CNT_MAX) m_errcnt = m_errcnt + 1'b1;
            m_errlast = es;
        end
        if (dv && m_dinvcnt != CNT_MAX) m_dinvcnt = m_dinvcnt + 1'b1;
        tick();
        bus.rd_data_valid = 1'b0;
        bus.errstat       = 7'd0;
        bus.dinv          = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_expected(input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(slot_exp[i]);
    endtask

    // Drains one batch, checking order, data, last flag, stall stability and completion.
    task automatic drain(input int len, input bit toggle, input string name);
        int            idx = 0;
        int            cyc = 0;
        bit            stalled = 0;
        bit            rdy;
        bit            v;
        logic [DW-1:0] held_d;
        logic [IW-1:0] held_i;
        logic [DW-1:0] exp_d;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s first_valid: got %b want 1", name, bus.out_valid);
        end
        while (idx < len && cyc < 300) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            v   = bus.out_valid;
            if (v) begin
                if (stalled) begin
                    checks++;
                    if (bus.out_idx !== held_i || bus.out_data !== held_d) begin
                        errors++;
                        $display("FAIL %s stall_hold: idx got %0d want %0d data got %h want %h",
                                 name, bus.out_idx, held_i, bus.out_data, held_d);
                    end
                end
                exp_d = (exp_q.size() > 0) ? exp_q[0] : 'x;
                checks++;
                if (bus.out_idx !== IW'(idx) || bus.out_data !== exp_d) begin
                    errors++;
                    $display("FAIL %s beat: idx got %0d want %0d data got %h want %h",
                             name, bus.out_idx, idx, bus.out_data, exp_d);
                end
                checks++;
                if (bus.out_last !== (idx == len - 1)) begin
                    errors++;
                    $display("FAIL %s out_last idx %0d: got %b want %b",
                             name, idx, bus.out_last, (idx == len - 1));
                end
                held_d = bus.out_data;
                held_i = bus.out_idx;
            end
            bus.out_ready = rdy;
            tick();
            cyc++;
            if (v && rdy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                idx++;
                stalled = 0;
            end else begin
                stalled = v;
            end
        end
        bus.out_ready = 1'b0;
        checks++;
        if (idx != len) begin
            errors++;
            $display("FAIL %s drain_timeout: got %0d beats want %0d", name, idx, len);
        end
        checks++;
        if (bus.batch_done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s completion: done=%b busy=%b valid=%b want 1 0 0",
                     name, bus.batch_done, bus.busy, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.batch_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got %b want 0", name, bus.batch_done);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.tag_err !== 1'b0 ||
            bus.batch_done !== 1'b0 || bus.out_last !== 1'b0 || bus.out_idx !== '0 ||
            bus.out_data !== '0 || bus.errstat_count !== '0 || bus.dinv_count !== '0 ||
            bus.errstat_last !== '0 || state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b err=%b done=%b idx=%0d state=%0d want all 0",
                     bus.out_valid, bus.busy, bus.tag_err, bus.batch_done, bus.out_idx, state_o);
        end
    endtask

    task automatic test_in_order();
        start_batch(32);
        check_bit("in_order busy", bus.busy, 1'b1);
        for (int t = 0; t < 32; t++) begin
            slot_exp[t] = rnd_data();
            send_rsp(t, slot_exp[t], 7'd0, 1'b0);
        end
        push_expected(32);
        drain(32, 1'b0, "in_order");
        check_bit("in_order tag_err", bus.tag_err, 1'b0);
    endtask

    task automatic test_reverse_backpressure();
        start_batch(8);
        for (int t = 7; t >= 0; t--) begin
            slot_exp[t] = rnd_data();
            send_rsp(t, slot_exp[t], 7'd0, 1'b0);
        end
        push_expected(8);
        drain(8, 1'b1, "reverse");
        check_bit("reverse tag_err", bus.tag_err, 1'b0);
    endtask

    task automatic test_illegal_tags();
        int            tags[6] = '{2, 2, 5, 0, 1, 3};
        logic [DW-1:0] d;
        bit            seen[4] = '{0, 0, 0, 0};
        start_batch(4);
        for (int i = 0; i < 6; i++) begin
            d = rnd_data();
            if (tags[i] < 4 && !seen[tags[i]]) begin
                slot_exp[tags[i]] = d;
                seen[tags[i]] = 1'b1;
            end
            send_rsp(tags[i], d, 7'd0, 1'b0);
        end
        push_expected(4);
        drain(4, 1'b0, "illegal_tags");
        check_bit("illegal_tags tag_err", bus.tag_err, 1'b1);
    endtask

    task automatic test_illegal_request();
        do_reset();
        start_batch(0);
        check_bit("req_len0 busy", bus.busy, 1'b0);
        check_bit("req_len0 tag_err", bus.tag_err, 1'b1);
        do_reset();
        start_batch(33);
        check_bit("req_len33 busy", bus.busy, 1'b0);
        check_bit("req_len33 tag_err", bus.tag_err, 1'b1);
        start_batch(1);
        check_bit("req_len1 busy", bus.busy, 1'b1);
        slot_exp[0] = rnd_data();
        send_rsp(0, slot_exp[0], 7'd0, 1'b0);
        push_expected(1);
        drain(1, 1'b0, "req_len1");
    endtask

    task automatic test_error_counters();
        do_reset();
        for (int i = 0; i < 3; i++) send_rsp(i, rnd_data(), 7'h05, 1'b0);
        send_rsp(9, rnd_data(), 7'd0, 1'b1);
        start_batch(1);
        slot_exp[0] = rnd_data();
        send_rsp(0, slot_exp[0], 7'd0, 1'b1);
        push_expected(1);
        drain(1, 1'b0, "counters_batch");
        checks++;
        if (bus.errstat_count !== m_errcnt || bus.errstat_last !== m_errlast ||
            bus.dinv_count !== m_dinvcnt || m_errcnt !== 16'd3 || m_dinvcnt !== 16'd2) begin
            errors++;
            $display("FAIL counters: errcnt got %0d want %0d last got %h want %h dinv got %0d want %0d",
                     bus.errstat_count, m_errcnt, bus.errstat_last, m_errlast,
                     bus.dinv_count, m_dinvcnt);
        end
        // Hold the strobe high to push the counter well past saturation.
        bus.rd_data_valid = 1'b1;
        bus.rd_data_tag   = TW'(63);
        bus.errstat       = 7'h01;
        for (int i = 0; i < 65540; i++) begin
            if (m_errcnt != CNT_MAX) m_errcnt = m_errcnt + 1'b1;
            tick();
        end
        m_errlast = 7'h01;
        bus.rd_data_valid = 1'b0;
        bus.errstat       = 7'd0;
        tick();
        checks++;
        if (bus.errstat_count !== m_errcnt || m_errcnt !== 16'hFFFF ||
            bus.errstat_last !== m_errlast) begin
            errors++;
            $display("FAIL errcnt_saturate: got %h want %h last got %h want %h",
                     bus.errstat_count, m_errcnt, bus.errstat_last, m_errlast);
        end
        check_bit("dinv_unchanged", bus.dinv_count === m_dinvcnt, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        int perm[16];
        bit done_seen = 0;
        start_batch(16);
        for (int t = 0; t < 10; t++) send_rsp(t, rnd_data(), 7'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.batch_done !== 1'b0) done_seen = 1;
            tick();
        end
        check_bit("midop no_done", done_seen, 1'b0);
        check_bit("midop busy", bus.busy, 1'b0);
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            int tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        start_batch(16);
        for (int i = 0; i < 16; i++) begin
            slot_exp[perm[i]] = rnd_data();
            send_rsp(perm[i], slot_exp[perm[i]], 7'd0, 1'b0);
        end
        push_expected(16);
        drain(16, 1'b0, "midop_new");
        check_bit("midop tag_err", bus.tag_err, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst               = 1'b1;
        bus.batch_start   = 1'b0;
        bus.batch_len     = '0;
        bus.rd_data       = '0;
        bus.rd_data_tag   = '0;
        bus.rd_data_valid = 1'b0;
        bus.errstat       = 7'd0;
        bus.dinv          = 1'b0;
        bus.out_ready     = 1'b0;
        tick();
        test_reset();
        test_in_order();
        test_reverse_backpressure();
        test_illegal_tags();
        test_illegal_request();
        test_error_counters();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
